// File: rtl/apb_multichannel_bridge.sv
// APB3 slave bridging CPU register accesses to CH_NUM channels through outbound/inbound FIFOs.
// One wait state minimum, more while the outbound FIFO is full. Optional IRQ: APB_BRIDGE_IRQ_EN.
module apb_multichannel_bridge #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 16,
   parameter int CH_NUM  = 4,
   parameter int CH_W    = 2,
   parameter int CFG_W   = 16,
   parameter int STAT_W  = 16,
   parameter int WRF_BIT = 3
) (
   input  logic                     pclk,
   input  logic                     preset_n,
   input  logic [ADDR_W-1:0]        paddr,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [DATA_W-1:0]        pwdata,
   output logic                     pready,
   output logic [DATA_W-1:0]        prdata,
   output logic                     pslverr,
   input  logic                     fifo_write_full,
   input  logic                     fifo_write_empty,
   output logic [CH_W+2+DATA_W-1:0] fifo_write_data,
   output logic                     fifo_write_inc,
   input  logic                     fifo_read_empty,
   input  logic [CH_W+2+DATA_W-1:0] fifo_read_data,
   output logic                     fifo_read_inc,
   output logic                     irq
);
   localparam int FW = CH_W + 2 + DATA_W;

   typedef enum logic [1:0] {IDLE, DECODE, WAIT_FIFO, RESP} state_t;

   state_t                        state_q, state_d;
   logic [CH_W-1:0]               sel_ch_q, sel_ch_d;
   logic [DATA_W-1:0]             prdata_q, prdata_d;
   logic                          pslverr_q, pslverr_d;
   logic                          wr_inc_q, wr_inc_d;
   logic [FW-1:0]                 wr_dat_q, wr_dat_d;
   logic                          rd_inc_q, rd_inc_d;
   logic [CH_NUM-1:0][CFG_W-1:0]  cfg_q, cfg_d;
   logic [CH_NUM-1:0][DATA_W-1:0] data_q, data_d;
   logic [CH_NUM-1:0][STAT_W-1:0] stat_q, stat_d;
   logic [CH_NUM-1:0]             wrf_q, wrf_d;
   logic                          push;

   logic a_cfg, a_data, a_stat, a_chan, a_mask, a_valid, a_err;
   assign a_cfg  = (paddr == ADDR_W'(1));
   assign a_data = (paddr == ADDR_W'(2));
   assign a_stat = (paddr == ADDR_W'(3));
   assign a_chan = (paddr == ADDR_W'(4));
`ifdef APB_BRIDGE_IRQ_EN
   logic [CH_NUM-1:0] mask_q, mask_d;
   logic              irq_q, irq_d;
   assign a_mask = (paddr == ADDR_W'(5));
`else
   assign a_mask = 1'b0;
`endif
   assign a_valid = a_cfg | a_data | a_stat | a_chan | a_mask;
   assign a_err   = !a_valid || (pwrite && a_stat) ||
                    (pwrite && a_chan && (pwdata >= DATA_W'(CH_NUM)));

   logic [CH_W-1:0]   in_ch;
   logic [1:0]        in_mod;
   logic [DATA_W-1:0] in_pld;
   assign in_ch  = fifo_read_data[FW-1 -: CH_W];
   assign in_mod = fifo_read_data[DATA_W +: 2];
   assign in_pld = fifo_read_data[DATA_W-1:0];

   // Read mux for the selected channel; FIFO levels are overlaid live onto STATUS.
   logic [DATA_W-1:0] rd_val;
   logic [STAT_W-1:0] stat_rd;
   logic [CFG_W-1:0]  cfg_rd;
   logic [DATA_W-1:0] data_rd;
   always_comb begin
      stat_rd = '0;
      cfg_rd  = '0;
      data_rd = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (sel_ch_q == CH_W'(c)) begin
            stat_rd          = stat_q[c];
            stat_rd[WRF_BIT] = wrf_q[c];
            cfg_rd           = cfg_q[c];
            data_rd          = data_q[c];
         end
      end
      stat_rd[8] = fifo_write_full;
      stat_rd[9] = fifo_write_empty;
      rd_val = '0;
      if (a_cfg)  rd_val = DATA_W'(cfg_rd);
      if (a_data) rd_val = data_rd;
      if (a_stat) rd_val = DATA_W'(stat_rd);
      if (a_chan) rd_val = DATA_W'(sel_ch_q);
`ifdef APB_BRIDGE_IRQ_EN
      if (a_mask) rd_val = DATA_W'(mask_q);
`endif
   end

   always_comb begin
      state_d   = state_q;
      sel_ch_d  = sel_ch_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      wr_inc_d  = 1'b0;
      wr_dat_d  = '0;
      cfg_d     = cfg_q;
      data_d    = data_q;
      stat_d    = stat_q;
      wrf_d     = wrf_q;
      push      = 1'b0;
`ifdef APB_BRIDGE_IRQ_EN
      mask_d    = mask_q;
`endif
      case (state_q)
         IDLE: begin
            if (psel && penable) state_d = DECODE;
         end
         DECODE: begin
            state_d = RESP;
            if (a_err) begin
               pslverr_d = 1'b1;
            end else if (!pwrite) begin
               prdata_d = rd_val;
               if (a_data) begin
                  for (int c = 0; c < CH_NUM; c++)
                     if (sel_ch_q == CH_W'(c)) wrf_d[c] = 1'b0;
               end
            end else if (a_cfg || a_data) begin
               if (fifo_write_full) state_d = WAIT_FIFO;
               else                 push    = 1'b1;
            end else if (a_chan) begin
               sel_ch_d = pwdata[CH_W-1:0];
            end
`ifdef APB_BRIDGE_IRQ_EN
            else begin
               mask_d = pwdata[CH_NUM-1:0];
            end
`endif
         end
         WAIT_FIFO: begin
            if (!fifo_write_full) begin
               push    = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d   = IDLE;
            prdata_d  = '0;
            pslverr_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         wr_inc_d = 1'b1;
         wr_dat_d = {sel_ch_q, (a_data ? 2'd1 : 2'd0), pwdata};
      end

      // Inbound words are consumed at most every other cycle; set beats a same-cycle clear.
      rd_inc_d = !fifo_read_empty && !rd_inc_q;
      if (rd_inc_d) begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (in_ch == CH_W'(c)) begin
               case (in_mod)
                  2'd0: cfg_d[c] = in_pld[CFG_W-1:0];
                  2'd1: begin
                     data_d[c] = in_pld;
                     wrf_d[c]  = 1'b1;
                  end
                  2'd2: begin
                     stat_d[c]          = in_pld[STAT_W-1:0];
                     stat_d[c][WRF_BIT] = 1'b0;
                     if (in_pld[WRF_BIT]) wrf_d[c] = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
`ifdef APB_BRIDGE_IRQ_EN
      irq_d = |(wrf_d & mask_d);
`endif
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q   <= IDLE;
         sel_ch_q  <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         wr_inc_q  <= 1'b0;
         wr_dat_q  <= '0;
         rd_inc_q  <= 1'b0;
         cfg_q     <= '0;
         data_q    <= '0;
         stat_q    <= '0;
         wrf_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_ch_q  <= sel_ch_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         wr_inc_q  <= wr_inc_d;
         wr_dat_q  <= wr_dat_d;
         rd_inc_q  <= rd_inc_d;
         cfg_q     <= cfg_d;
         data_q    <= data_d;
         stat_q    <= stat_d;
         wrf_q     <= wrf_d;
      end
   end

`ifdef APB_BRIDGE_IRQ_EN
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign pready          = (state_q == RESP);
   assign prdata          = prdata_q;
   assign pslverr         = pslverr_q;
   assign fifo_write_inc  = wr_inc_q;
   assign fifo_write_data = wr_dat_q;
   assign fifo_read_inc   = rd_inc_q;

endmodule

// File: tb/tb_apb_multichannel_bridge.sv
// Randomized bench for apb_multichannel_bridge against a register-level behavioural model.
`timescale 1ns/1ps
module tb_apb_multichannel_bridge;
   localparam int DATA_W = 32, ADDR_W = 16, CH_NUM = 3, CH_W = 2;
   localparam int CFG_W = 16, STAT_W = 16, WRF_BIT = 3;
   localparam int FW = CH_W + 2 + DATA_W;

   logic              pclk = 1'b0;
   logic              preset_n = 1'b1;
   logic [ADDR_W-1:0] paddr = '0;
   logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [DATA_W-1:0] pwdata = '0;
   logic              pready, pslverr, fifo_write_inc, fifo_read_inc, irq;
   logic [DATA_W-1:0] prdata;
   logic [FW-1:0]     fifo_write_data;
   logic              fifo_write_full = 1'b0, fifo_write_empty = 1'b1;
   logic              fifo_read_empty = 1'b1;
   logic [FW-1:0]     fifo_read_data = '0;

   apb_multichannel_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_NUM(CH_NUM), .CH_W(CH_W),
      .CFG_W(CFG_W), .STAT_W(STAT_W), .WRF_BIT(WRF_BIT)) dut (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .fifo_write_full(fifo_write_full), .fifo_write_empty(fifo_write_empty),
      .fifo_write_data(fifo_write_data), .fifo_write_inc(fifo_write_inc),
      .fifo_read_empty(fifo_read_empty), .fifo_read_data(fifo_read_data),
      .fifo_read_inc(fifo_read_inc), .irq(irq));

   always #5 pclk = ~pclk;

   int total = 0, bad = 0;
   int cyc = 0, idle_dat_err = 0, rd_b2b_err = 0;

   // Behavioural register model of the channels
   logic [CFG_W-1:0]  m_cfg  [CH_NUM];
   logic [DATA_W-1:0] m_data [CH_NUM];
   logic [STAT_W-1:0] m_stat [CH_NUM];
   logic              m_wrf  [CH_NUM];
   int                m_sel;
   logic [CH_NUM-1:0] m_mask;
   logic [FW-1:0]     in_q[$], exp_push[$], got_push[$];
   int                rd_cyc[$];

   task automatic model_reset();
      for (int c = 0; c < CH_NUM; c++) begin
         m_cfg[c] = '0; m_data[c] = '0; m_stat[c] = '0; m_wrf[c] = 1'b0;
      end
      m_sel = 0; m_mask = '0;
   endtask

   function automatic logic model_irq();
      logic r = 1'b0;
      for (int c = 0; c < CH_NUM; c++) r = r | (m_wrf[c] & m_mask[c]);
`ifdef APB_BRIDGE_IRQ_EN
      return r;
`else
      return 1'b0;
`endif
   endfunction

   task automatic apply_inbound(input logic [FW-1:0] w);
      int ch, md;
      logic [DATA_W-1:0] pld;
      ch = int'(w[FW-1 -: CH_W]); md = int'(w[DATA_W +: 2]); pld = w[DATA_W-1:0];
      if (ch >= CH_NUM) return;
      if (md == 0) m_cfg[ch] = pld[CFG_W-1:0];
      if (md == 1) begin m_data[ch] = pld; m_wrf[ch] = 1'b1; end
      if (md == 2) begin
         m_stat[ch] = pld[STAT_W-1:0] & ~(16'(1) << WRF_BIT);
         if (pld[WRF_BIT]) m_wrf[ch] = 1'b1;
      end
   endtask

   function automatic logic [31:0] exp_status(int c);
      return 32'(m_stat[c] & ~16'h0308) | (32'(m_wrf[c]) << WRF_BIT) |
             (32'(fifo_write_full) << 8) | (32'(fifo_write_empty) << 9);
   endfunction

   task automatic model_access(input logic w, input int addr, input logic [31:0] wd,
                               output logic exp_err, output logic [31:0] exp_rd);
      logic valid;
      valid = (addr >= 1 && addr <= 4);
`ifdef APB_BRIDGE_IRQ_EN
      if (addr == 5) valid = 1'b1;
`endif
      exp_rd  = '0;
      exp_err = !valid || (w && addr == 3) || (w && addr == 4 && wd >= 32'(CH_NUM));
      if (exp_err) return;
      if (w) begin
         if (addr == 1 || addr == 2) exp_push.push_back({2'(m_sel), 2'(addr - 1), wd});
         if (addr == 4) m_sel = int'(wd);
         if (addr == 5) m_mask = wd[CH_NUM-1:0];
      end else begin
         case (addr)
            1: exp_rd = 32'(m_cfg[m_sel]);
            2: begin exp_rd = m_data[m_sel]; m_wrf[m_sel] = 1'b0; end
            3: exp_rd = exp_status(m_sel);
            4: exp_rd = 32'(m_sel);
            default: exp_rd = 32'(m_mask);
         endcase
      end
   endtask

   task automatic refresh_in();
      fifo_read_empty = (in_q.size() == 0);
      fifo_read_data  = (in_q.size() == 0) ? '0 : in_q[0];
   endtask

   task automatic push_in(input int ch, input int md, input logic [31:0] pld);
      in_q.push_back({2'(ch), 2'(md), pld});
      refresh_in();
   endtask

   // Inbound FIFO emulation and output monitor
   initial begin
      logic prev_rd = 1'b0;
      forever begin
         @(negedge pclk);
         cyc++;
         if (fifo_read_inc && prev_rd) rd_b2b_err++;
         prev_rd = fifo_read_inc;
         if (!fifo_write_inc && fifo_write_data != '0) idle_dat_err++;
         if (fifo_write_inc) got_push.push_back(fifo_write_data);
         if (fifo_read_inc && in_q.size() > 0) begin
            rd_cyc.push_back(cyc);
            apply_inbound(in_q[0]);
            void'(in_q.pop_front());
            refresh_in();
         end
      end
   end

   task automatic apb(input logic w, input int addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = 16'(addr); pwdata = wd;
      @(negedge pclk);
      penable = 1'b1; lat = 0;
      while (lat < 60) begin
         @(negedge pclk);
         lat++;
         if (pready) break;
      end
      if (!pready) begin
         total++; bad++;
         $display("FAIL apb_timeout addr=%0d pready=%0b required=1", addr, pready);
      end
      rd = prdata; err = pslverr;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      @(negedge pclk);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (in_q.size() > 0 && n < 100) begin @(negedge pclk); n++; end
      if (in_q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain_timeout left=%0d required=0", in_q.size());
      end
      repeat (3) @(negedge pclk);
   endtask

   task automatic test_reset();
      logic [31:0] rd, er; logic err; int lat;
      #1 preset_n = 1'b0;
      repeat (3) @(negedge pclk);
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL rst_pready got=%b exp=0", pready); end
      total++; if (prdata !== '0) begin bad++; $display("FAIL rst_prdata got=%h exp=0", prdata); end
      total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL rst_pslverr got=%b exp=0", pslverr); end
      total++; if (fifo_write_inc !== 1'b0 || fifo_write_data !== '0) begin
         bad++; $display("FAIL rst_wr got=%b/%h exp=0/0", fifo_write_inc, fifo_write_data); end
      total++; if (fifo_read_inc !== 1'b0) begin bad++; $display("FAIL rst_rd_inc got=%b exp=0", fifo_read_inc); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
      preset_n = 1'b1;
      model_reset();
      @(negedge pclk);
      model_access(1'b0, 4, 0, err, er);
      apb(1'b0, 4, 0, rd, err, lat);
      total++; if (rd !== er) begin bad++; $display("FAIL rst_sel_ch got=%h exp=%h", rd, er); end
      model_access(1'b0, 3, 0, err, er);
      apb(1'b0, 3, 0, rd, err, lat);
      total++; if (rd !== er) begin bad++; $display("FAIL rst_status got=%h exp=%h", rd, er); end
   endtask

   task automatic test_config_write();
      logic [31:0] rd, er; logic err, eerr; int lat;
      logic [FW-1:0] exp_w;
      exp_w = {2'd2, 2'd0, 32'h0000_00A5};
      model_access(1'b1, 4, 2, eerr, er);
      apb(1'b1, 4, 2, rd, err, lat);
      got_push.delete(); exp_push.delete();
      model_access(1'b1, 1, 32'hA5, eerr, er);
      apb(1'b1, 1, 32'hA5, rd, err, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL cfg_latency got=%0d exp=2", lat); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL cfg_slverr got=%b exp=0", err); end
      total++; if (got_push.size() != 1) begin bad++; $display("FAIL cfg_push_count got=%0d exp=1", got_push.size()); end
      else if (got_push[0] !== exp_w) begin bad++; $display("FAIL cfg_push_data got=%h exp=%h", got_push[0], exp_w); end
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL cfg_pready_one_cycle got=%b exp=0", pready); end
      got_push.delete(); exp_push.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, er; logic err, eerr; int lat, stall_err;
      logic [FW-1:0] exp_w;
      exp_w = {2'd2, 2'd1, 32'h1234_5678};
      stall_err = 0;
      model_access(1'b1, 2, 32'h1234_5678, eerr, er);
      fifo_write_full = 1'b1;
      fork
         apb(1'b1, 2, 32'h1234_5678, rd, err, lat);
         begin
            repeat (6) begin
               @(negedge pclk);
               if (pready || fifo_write_inc) stall_err++;
            end
            fifo_write_full = 1'b0;
         end
      join
      total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stall got=%0d exp=0", stall_err); end
      total++; if (lat != 6) begin bad++; $display("FAIL bp_latency got=%0d exp=6", lat); end
      total++; if (got_push.size() != 1) begin bad++; $display("FAIL bp_push_count got=%0d exp=1", got_push.size()); end
      else if (got_push[0] !== exp_w) begin bad++; $display("FAIL bp_push_data got=%h exp=%h", got_push[0], exp_w); end
      got_push.delete(); exp_push.delete();
   endtask

   task automatic test_errors();
      logic [31:0] rd, er; logic err, eerr; int lat;
      int addrs[6] = '{7, 3, 4, 0, 0, 5};
      logic wrs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         model_access(wrs[i], addrs[i], 32'h3, eerr, er);
         apb(wrs[i], addrs[i], 32'h3, rd, err, lat);
         total++; if (err !== eerr || rd !== er) begin
            bad++; $display("FAIL err_case%0d got=%b/%h exp=%b/%h", i, err, rd, eerr, er); end
      end
      model_access(1'b0, 4, 0, eerr, er);
      apb(1'b0, 4, 0, rd, err, lat);
      total++; if (rd !== er) begin bad++; $display("FAIL err_sel_kept got=%h exp=%h", rd, er); end
      total++; if (got_push.size() != 0) begin bad++; $display("FAIL err_no_push got=%0d exp=0", got_push.size()); end
      got_push.delete(); exp_push.delete();
   endtask

   task automatic test_inbound_data();
      logic [31:0] rd, er; logic err, eerr; int lat;
      model_access(1'b1, 4, 1, eerr, er);
      apb(1'b1, 4, 1, rd, err, lat);
      push_in(1, 1, 32'hDEAD_BEEF);
      wait_drain();
      model_access(1'b0, 3, 0, eerr, er);
      apb(1'b0, 3, 0, rd, err, lat);
      total++; if (rd[WRF_BIT] !== 1'b1 || rd !== er) begin bad++; $display("FAIL wrf_set got=%h exp=%h", rd, er); end
      model_access(1'b0, 2, 0, eerr, er);
      apb(1'b0, 2, 0, rd, err, lat);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL data_read got=%h exp=deadbeef", rd); end
      model_access(1'b0, 3, 0, eerr, er);
      apb(1'b0, 3, 0, rd, err, lat);
      total++; if (rd[WRF_BIT] !== 1'b0 || rd !== er) begin bad++; $display("FAIL wrf_clear got=%h exp=%h", rd, er); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, er; logic err, eerr; int lat;
      rd_cyc.delete();
      push_in(0, 0, 32'h0000_1111);
      push_in(3, 1, 32'h0000_0BAD);
      push_in(2, 2, 32'h0000_00F8);
      wait_drain();
      total++; if (rd_cyc.size() != 3) begin bad++; $display("FAIL b2b_pops got=%0d exp=3", rd_cyc.size()); end
      else if (rd_cyc[1] - rd_cyc[0] != 2 || rd_cyc[2] - rd_cyc[1] != 2) begin
         bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=2,2", rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1]); end
      total++; if (rd_b2b_err != 0) begin bad++; $display("FAIL b2b_adjacent got=%0d exp=0", rd_b2b_err); end
      for (int c = 0; c < CH_NUM; c++) begin
         model_access(1'b1, 4, 32'(c), eerr, er);
         apb(1'b1, 4, 32'(c), rd, err, lat);
         for (int a = 1; a <= 3; a++) begin
            model_access(1'b0, a, 0, eerr, er);
            apb(1'b0, a, 0, rd, err, lat);
            total++; if (rd !== er || err !== 1'b0) begin
               bad++; $display("FAIL shadow ch%0d reg%0d got=%h exp=%h", c, a, rd, er); end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, er, wd; logic err, eerr, w; int lat, addr;
      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < int'($urandom_range(0, 3)); k++)
            push_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
         wait_drain();
         for (int k = 0; k < 3; k++) begin
            addr = int'($urandom_range(0, 6));
            w = 1'($urandom_range(0, 1));
            wd = (addr == 4) ? 32'($urandom_range(0, 4)) : $urandom;
            fifo_write_empty = 1'($urandom_range(0, 1));
            model_access(w, addr, wd, eerr, er);
            apb(w, addr, wd, rd, err, lat);
            total++; if (rd !== er || err !== eerr || lat != 2) begin
               bad++; $display("FAIL rand it%0d a%0d w%0b got=%h/%b/%0d exp=%h/%b/2", it, addr, w, rd, err, lat, er, eerr); end
         end
         total++; if (got_push != exp_push) begin
            bad++; $display("FAIL rand_push it%0d got_n=%0d exp_n=%0d", it, got_push.size(), exp_push.size()); end
         total++; if (irq !== model_irq()) begin bad++; $display("FAIL rand_irq got=%b exp=%b", irq, model_irq()); end
         got_push.delete(); exp_push.delete();
      end
      fifo_write_empty = 1'b1;
      total++; if (idle_dat_err != 0) begin bad++; $display("FAIL wr_data_idle got=%0d exp=0", idle_dat_err); end
   endtask

   task automatic test_irq();
      logic [31:0] rd, er; logic err, eerr; int lat;
      for (int c = 0; c < CH_NUM; c++) begin
         model_access(1'b1, 4, 32'(c), eerr, er); apb(1'b1, 4, 32'(c), rd, err, lat);
         model_access(1'b0, 2, 0, eerr, er); apb(1'b0, 2, 0, rd, err, lat);
      end
      model_access(1'b1, 5, 32'b0010, eerr, er);
      apb(1'b1, 5, 32'b0010, rd, err, lat);
      push_in(1, 1, 32'h0000_0055);
      wait_drain();
`ifdef APB_BRIDGE_IRQ_EN
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
`else
      total++; if (err !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL irq_off got=%b/%b exp=1/0", err, irq); end
`endif
      model_access(1'b1, 4, 1, eerr, er); apb(1'b1, 4, 1, rd, err, lat);
      model_access(1'b0, 2, 0, eerr, er); apb(1'b0, 2, 0, rd, err, lat);
      total++; if (irq !== 1'b0 || rd !== 32'h55) begin bad++; $display("FAIL irq_clear got=%b/%h exp=0/55", irq, rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, er; logic err, eerr; int lat;
      got_push.delete();
      fifo_write_full = 1'b1;
      psel = 1'b1; pwrite = 1'b1; paddr = 16'd2; pwdata = 32'hCAFE_0001;
      @(negedge pclk); penable = 1'b1;
      repeat (3) @(negedge pclk);
      preset_n = 1'b0;
      #1;
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL mid_rst_pready got=%b exp=0", pready); end
      fifo_write_full = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (2) @(negedge pclk);
      preset_n = 1'b1;
      model_reset();
      repeat (3) @(negedge pclk);
      total++; if (got_push.size() != 0) begin bad++; $display("FAIL mid_rst_push got=%0d exp=0", got_push.size()); end
      model_access(1'b0, 1, 0, eerr, er);
      apb(1'b0, 1, 0, rd, err, lat);
      total++; if (rd !== er || lat != 2) begin bad++; $display("FAIL mid_rst_after got=%h/%0d exp=%h/2", rd, lat, er); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_config_write();
      test_backpressure();
      test_errors();
      test_inbound_data();
      test_back_to_back();
      test_random();
      test_irq();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb_multichannel_bridge.md
Name: apb_multichannel_bridge

Overview:
- APB3 slave that bridges CPU register accesses to CH_NUM transceiver channels through a pair of async FIFOs.
- CPU writes are tagged with channel and register modifier and pushed into the outbound FIFO.
- Words from the inbound FIFO update per-channel shadow CONFIG/DATA/STATUS registers, which the CPU reads for the currently selected channel.
- Adds over-the-previous-generation features: back-pressure wait states, pslverr, and sticky per-channel word-received flags.

Parameters:
- DATA_W, 32: APB data and payload width.
- ADDR_W, 16: paddr width.
- CH_NUM, 4: number of channels (1..2**CH_W).
- CH_W, 2: channel-id field width.
- CFG_W, 16: shadow CONFIG width (≤ DATA_W).
- STAT_W, 16: shadow STATUS width (≤ DATA_W, > 9).
- WRF_BIT, 3: word-received flag position in STATUS.

Ports:
- pclk  in  1  APB clock
- preset_n  in  1  asynchronous active-low reset
- paddr  in  ADDR_W  byte-agnostic register index
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1 = write
- pwdata  in  DATA_W  write data
- pready  out  1  transfer complete
- prdata  out  DATA_W  read data
- pslverr  out  1  error response
- fifo_write_full  in  1  outbound FIFO full
- fifo_write_empty  in  1  outbound FIFO empty
- fifo_write_data  out  CH_W+2+DATA_W  {ch, modifier, payload}
- fifo_write_inc  out  1  outbound push strobe
- fifo_read_empty  in  1  inbound FIFO empty
- fifo_read_data  in  CH_W+2+DATA_W  show-ahead inbound word {ch, modifier, payload}
- fifo_read_inc  out  1  inbound pop strobe
- irq  out  1  see Optional Feature (tied 0 when the feature is off)

Behaviour:
- Reset: clock pclk; reset preset_n, asynchronous, active-low. All outputs are 0; sel_ch = 0; all shadow registers are 0; FSM in IDLE.
- Register map:
  - 1 = CONFIG (R/W, forwarded, modifier 0)
  - 2 = DATA (R/W, forwarded, modifier 1)
  - 3 = STATUS (RO, modifier 2)
  - 4 = CHANNEL (R/W, local only, holds sel_ch)
  - Any other address is invalid.
- FSM states: IDLE, DECODE, WAIT_FIFO, RESP.
  - IDLE -> DECODE on psel & penable.
  - DECODE outcomes:
    - Invalid address, write to STATUS, or CHANNEL write with pwdata ≥ CH_NUM: -> RESP with pslverr = 1, no side effects.
    - Forwarded write with fifo_write_full = 1: -> WAIT_FIFO.
    - Forwarded write with FIFO not full: push, -> RESP.
    - Read: prdata <= selected value, -> RESP.
    - CHANNEL write: sel_ch <= pwdata[CH_W-1:0], -> RESP.
  - WAIT_FIFO: stays while full with pready = 0; pushes and -> RESP the first cycle full = 0.
  - RESP: pready = 1 for exactly one cycle, pslverr valid, then -> IDLE.
  - Minimum latency is one wait state: pready rises 2 cycles after the access phase starts.
- Push: fifo_write_inc is a single-cycle pulse with fifo_write_data = {sel_ch, modifier, pwdata}. fifo_write_data returns to 0 the next cycle. Exactly one push per write transfer.
- prdata is 0 except during RESP of a successful read.
  - STATUS read returns the shadow status of sel_ch, with bit 8 = live fifo_write_full and bit 9 = live fifo_write_empty (sampled in DECODE).
  - Narrow registers are zero-extended.
- Inbound pop:
  - When fifo_read_empty = 0 and fifo_read_inc = 0, the block consumes fifo_read_data and pulses fifo_read_inc for one cycle. Pops are therefore never back-to-back (max 1 word / 2 cycles).
  - Words with ch ≥ CH_NUM or modifier 3 are popped and discarded.
  - Modifier 0/1 load CONFIG/DATA of channel ch. Modifier 2 loads STATUS of ch, except WRF_BIT.
- WRF per channel is sticky:
  - Set when an inbound STATUS word has WRF_BIT = 1 or an inbound DATA word arrives.
  - Cleared in DECODE of a successful DATA read of that channel.
  - Simultaneous set and clear: set wins.
- Reset mid-transfer: FSM returns to IDLE and pready = 0; a pending push is lost.

Optional Feature:
- Macro: APB_BRIDGE_IRQ_EN.
- Defined:
  - Extra register 5 = IRQ_MASK (R/W, CH_NUM bits, reset 0).
  - irq is registered and equals OR over channels of (WRF[c] & mask[c]). It drops the cycle after the clearing DATA read.
- Undefined: address 5 is invalid (pslverr) and irq is constant 0.

Test Plan:
- Write CONFIG=0x0000_00A5 with sel_ch=2, FIFO not full -> one fifo_write_inc pulse, fifo_write_data={2,0,0xA5}; pready high 2 cycles after penable; pslverr=0.
- fifo_write_full=1 for 5 cycles during a DATA write -> pready low throughout, no push; push and pready occur after full drops.
- Read address 7, then write STATUS -> both RESP with pslverr=1, no push, no register change.
- Inbound {1,1,0xDEAD_BEEF}, sel_ch=1 -> DATA read returns 0xDEADBEEF; STATUS bit3 =1 before the read, 0 after.
- Three inbound words back-to-back -> fifo_read_inc pulses on alternating cycles; a ch=3 word with CH_NUM=3 leaves all shadows unchanged.
- APB_BRIDGE_IRQ_EN: mask=0b0010, inbound DATA on ch1 -> irq=1; DATA read of ch1 -> irq=0 the next cycle.
